// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution sequencer.
// Latency: n/a (types and an elaboration-time function only).
// Backpressure: n/a.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        ACCUM  = 3'd2,
        DRAIN  = 3'd3,
        OUTPUT = 3'd4,
        DONE   = 3'd5
    } conv_state_t;

    // Number of window positions; guarded so illegal parameter sets still
    // elaborate far enough to reach the legality checks in the top.
    function automatic int n_out(input int x, input int f, input int s);
        if (s < 1 || x < f) begin
            return 1;
        end
        return (x - f) / s + 1;
    endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// 1-bit delay line: dout is din delayed by DEPTH cycles (DEPTH=0 is a wire).
// Latency: DEPTH cycles. Backpressure: none; clear empties the line synchronously.
// Ports: clk, reset (async, active-high), clear (sync flush), din, dout.
module ctrl_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic din,
    output logic dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
            // clk/reset/clear have no job in the zero-depth form.
            logic unused_ok;
            assign unused_ok = clk ^ reset ^ clear;
        end else begin : g_shift
            logic [DEPTH-1:0] sr;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sr <= '0;
                end else if (clear) begin
                    sr <= '0;
                end else begin
                    sr <= (sr << 1) | DEPTH'(din);
                end
            end
            assign dout = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/ctrl_conv_seq.sv
// Convolution control sequencer: walks a sliding window over x, issues tap reads, frames accumulation, hands results out.
// Latency: 1 + F_MEM_SIZE + PIPE_LAT + 1 cycles per output with the consumer always ready.
// Backpressure: m_valid_y holds in OUTPUT until m_ready_y; no new reads are issued meanwhile.
// Ports: clk, reset (async, active-high), conv_start (level enable, rising edge starts),
//        m_ready_y; x_addr/f_addr/rd_en to memories, reset_accum/en_accum to the MAC,
//        m_valid_y/out_idx to the consumer, conv_done end-of-run pulse.
module ctrl_conv_seq
    import conv_pkg::*;
#(
    parameter int F_MEM_SIZE       = 4,
    parameter int X_MEM_SIZE       = 8,
    parameter int STRIDE           = 1,
    parameter int PIPE_LAT         = 1,
    parameter int X_MEM_ADDR_WIDTH = 3,
    parameter int F_MEM_ADDR_WIDTH = 2,
    localparam int N_OUT           = n_out(X_MEM_SIZE, F_MEM_SIZE, STRIDE),
    localparam int OUT_IDX_W       = $clog2(N_OUT + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        conv_start,
    input  logic                        m_ready_y,
    output logic [X_MEM_ADDR_WIDTH-1:0] x_addr,
    output logic [F_MEM_ADDR_WIDTH-1:0] f_addr,
    output logic                        rd_en,
    output logic                        reset_accum,
    output logic                        en_accum,
    output logic                        m_valid_y,
    output logic [OUT_IDX_W-1:0]        out_idx,
    output logic                        conv_done
);

    localparam int XW = X_MEM_ADDR_WIDTH;
    localparam int FW = F_MEM_ADDR_WIDTH;
    localparam int KW = (F_MEM_SIZE > 1) ? $clog2(F_MEM_SIZE) : 1;
    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    generate
        if (STRIDE < 1 || STRIDE > F_MEM_SIZE) begin : g_bad_stride
            $fatal(1, "ctrl_conv_seq: STRIDE must be within 1..F_MEM_SIZE");
        end
        if (PIPE_LAT < 0 || PIPE_LAT > 4) begin : g_bad_lat
            $fatal(1, "ctrl_conv_seq: PIPE_LAT must be within 0..4");
        end
        if (F_MEM_SIZE < 1 || F_MEM_SIZE > X_MEM_SIZE) begin : g_bad_size
            $fatal(1, "ctrl_conv_seq: need 1 <= F_MEM_SIZE <= X_MEM_SIZE");
        end
    endgenerate

    conv_state_t   state;
    logic [XW-1:0] base;
    logic [KW-1:0] k;
    logic [KW-1:0] k_nxt;
    logic [DW-1:0] dcnt;
    logic          start_q;
    logic          armed;
    logic          abort_pend;
    logic          start_edge;
    logic          abort;

    assign k_nxt = k + KW'(1);

    // armed stays low after reset until conv_start is seen low, so a level
    // already high at reset release cannot masquerade as a rising edge.
    assign start_edge = conv_start && !start_q && armed;

    // Immediate abort only before a result exists; OUTPUT defers it.
    assign abort = !conv_start && (state inside {CLEAR, ACCUM, DRAIN});

    ctrl_delay_line #(
        .DEPTH (PIPE_LAT)
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .clear (abort),
        .din   (rd_en),
        .dout  (en_accum)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            base        <= '0;
            k           <= '0;
            dcnt        <= '0;
            start_q     <= 1'b0;
            armed       <= 1'b0;
            abort_pend  <= 1'b0;
            x_addr      <= '0;
            f_addr      <= '0;
            rd_en       <= 1'b0;
            reset_accum <= 1'b0;
            m_valid_y   <= 1'b0;
            out_idx     <= '0;
            conv_done   <= 1'b0;
        end else begin
            start_q     <= conv_start;
            armed       <= armed | ~conv_start;
            reset_accum <= 1'b0;
            conv_done   <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state       <= CLEAR;
                        base        <= '0;
                        out_idx     <= '0;
                        abort_pend  <= 1'b0;
                        reset_accum <= 1'b1;
                    end
                end

                CLEAR: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        state  <= ACCUM;
                        k      <= '0;
                        rd_en  <= 1'b1;
                        x_addr <= base;
                        f_addr <= '0;
                    end
                end

                ACCUM: begin
                    if (abort) begin
                        state <= IDLE;
                        rd_en <= 1'b0;
                    end else if (k == KW'(F_MEM_SIZE - 1)) begin
                        rd_en <= 1'b0;
                        dcnt  <= '0;
                        if (PIPE_LAT == 0) begin
                            state     <= OUTPUT;
                            m_valid_y <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        k      <= k_nxt;
                        x_addr <= base + XW'(k_nxt);
                        f_addr <= FW'(k_nxt);
                    end
                end

                DRAIN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (dcnt == DW'(PIPE_LAT - 1)) begin
                        state     <= OUTPUT;
                        m_valid_y <= 1'b1;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end

                OUTPUT: begin
                    // A drop of conv_start is remembered so that a drop that
                    // recovers before the handshake still ends the run.
                    if (!conv_start) begin
                        abort_pend <= 1'b1;
                    end
                    if (m_ready_y) begin
                        m_valid_y <= 1'b0;
                        if (abort_pend || !conv_start) begin
                            state <= IDLE;
                        end else if (out_idx == OUT_IDX_W'(N_OUT - 1)) begin
                            state     <= DONE;
                            conv_done <= 1'b1;
                        end else begin
                            state       <= CLEAR;
                            reset_accum <= 1'b1;
                            base        <= base + XW'(STRIDE);
                            out_idx     <= out_idx + OUT_IDX_W'(1);
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_conv_seq.sv
module tb_ctrl_conv_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // DUT a: defaults (F=4, X=8, S=1, L=1)
    logic       cs_a, rdy_a;
    logic [2:0] xa_a;
    logic [1:0] fa_a;
    logic       rd_a, ra_a, ea_a, mv_a, dn_a;
    logic [2:0] oi_a;

    // DUT b: F=3, X=9, S=2, L=2
    logic       cs_b, rdy_b;
    logic [3:0] xa_b;
    logic [1:0] fa_b;
    logic       rd_b, ra_b, ea_b, mv_b, dn_b;
    logic [2:0] oi_b;

    // DUT c: defaults with L=0
    logic       cs_c, rdy_c;
    logic [2:0] xa_c;
    logic [1:0] fa_c;
    logic       rd_c, ra_c, ea_c, mv_c, dn_c;
    logic [2:0] oi_c;

    ctrl_conv_seq u_dut_a (
        .clk(clk), .reset(reset), .conv_start(cs_a), .m_ready_y(rdy_a),
        .x_addr(xa_a), .f_addr(fa_a), .rd_en(rd_a), .reset_accum(ra_a),
        .en_accum(ea_a), .m_valid_y(mv_a), .out_idx(oi_a), .conv_done(dn_a)
    );

    ctrl_conv_seq #(
        .F_MEM_SIZE(3), .X_MEM_SIZE(9), .STRIDE(2), .PIPE_LAT(2),
        .X_MEM_ADDR_WIDTH(4), .F_MEM_ADDR_WIDTH(2)
    ) u_dut_b (
        .clk(clk), .reset(reset), .conv_start(cs_b), .m_ready_y(rdy_b),
        .x_addr(xa_b), .f_addr(fa_b), .rd_en(rd_b), .reset_accum(ra_b),
        .en_accum(ea_b), .m_valid_y(mv_b), .out_idx(oi_b), .conv_done(dn_b)
    );

    ctrl_conv_seq #(.PIPE_LAT(0)) u_dut_c (
        .clk(clk), .reset(reset), .conv_start(cs_c), .m_ready_y(rdy_c),
        .x_addr(xa_c), .f_addr(fa_c), .rd_en(rd_c), .reset_accum(ra_c),
        .en_accum(ea_c), .m_valid_y(mv_c), .out_idx(oi_c), .conv_done(dn_c)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs t cycles after the start edge (t=0 is CLEAR of output 0)
    // for an uninterrupted run with the consumer always ready.
    function automatic void exp_at(input int t, input int f, input int s, input int l,
                                   input int n, output logic [4:0] ctl,
                                   output int xa, output int fa, output int oi);
        int p, o, c;
        logic rd, ra, ea, mv, dn;
        p = f + l + 2;
        o = t / p;
        c = t % p;
        rd = 1'b0; ra = 1'b0; ea = 1'b0; mv = 1'b0; dn = 1'b0;
        xa = 0; fa = 0; oi = n - 1;
        if (o < n) begin
            oi = o;
            ra = (c == 0);
            rd = (c >= 1 && c <= f);
            ea = (c >= 1 + l && c <= f + l);
            mv = (c == f + l + 1);
            xa = o * s + c - 1;
            fa = c - 1;
        end else if (t == n * p) begin
            dn = 1'b1;
        end
        ctl = {rd, ra, ea, mv, dn};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        cs_a = 1'b0; cs_b = 1'b0; cs_c = 1'b0;
        rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1;
        repeat (3) tick();
        total_cnt++;
        if ({xa_a, fa_a, rd_a, ra_a, ea_a, mv_a, oi_a, dn_a} !== '0)
            $display("FAIL reset_a: got %b want all zero", {xa_a, fa_a, rd_a, ra_a, ea_a, mv_a, oi_a, dn_a});
        else pass_cnt++;
        total_cnt++;
        if ({xa_b, fa_b, rd_b, ra_b, ea_b, mv_b, oi_b, dn_b} !== '0)
            $display("FAIL reset_b: got %b want all zero", {xa_b, fa_b, rd_b, ra_b, ea_b, mv_b, oi_b, dn_b});
        else pass_cnt++;
        total_cnt++;
        if ({xa_c, fa_c, rd_c, ra_c, ea_c, mv_c, oi_c, dn_c} !== '0)
            $display("FAIL reset_c: got %b want all zero", {xa_c, fa_c, rd_c, ra_c, ea_c, mv_c, oi_c, dn_c});
        else pass_cnt++;
        reset = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_default_run();
        logic [4:0] e_ctl;
        int e_x, e_f, e_o;
        cs_a = 1'b1;
        tick();
        for (int t = 0; t <= 36; t++) begin
            exp_at(t, 4, 1, 1, 5, e_ctl, e_x, e_f, e_o);
            total_cnt++;
            if ({rd_a, ra_a, ea_a, mv_a, dn_a} !== e_ctl)
                $display("FAIL default_ctl t=%0d: got %b want %b (rd,ra,ea,mv,dn)", t, {rd_a, ra_a, ea_a, mv_a, dn_a}, e_ctl);
            else pass_cnt++;
            total_cnt++;
            if (oi_a !== 3'(e_o))
                $display("FAIL default_idx t=%0d: got %0d want %0d", t, oi_a, e_o);
            else pass_cnt++;
            if (e_ctl[4]) begin
                total_cnt++;
                if ({xa_a, fa_a} !== {3'(e_x), 2'(e_f)})
                    $display("FAIL default_addr t=%0d: got x=%0d f=%0d want x=%0d f=%0d", t, xa_a, fa_a, e_x, e_f);
                else pass_cnt++;
            end
            tick();
        end
        cs_a = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_stride_pipe();
        logic [4:0] e_ctl;
        int e_x, e_f, e_o;
        cs_b = 1'b1;
        tick();
        for (int t = 0; t <= 29; t++) begin
            exp_at(t, 3, 2, 2, 4, e_ctl, e_x, e_f, e_o);
            total_cnt++;
            if ({rd_b, ra_b, ea_b, mv_b, dn_b} !== e_ctl)
                $display("FAIL stride_ctl t=%0d: got %b want %b (rd,ra,ea,mv,dn)", t, {rd_b, ra_b, ea_b, mv_b, dn_b}, e_ctl);
            else pass_cnt++;
            total_cnt++;
            if (oi_b !== 3'(e_o))
                $display("FAIL stride_idx t=%0d: got %0d want %0d", t, oi_b, e_o);
            else pass_cnt++;
            if (e_ctl[4]) begin
                total_cnt++;
                if ({xa_b, fa_b} !== {4'(e_x), 2'(e_f)})
                    $display("FAIL stride_addr t=%0d: got x=%0d f=%0d want x=%0d f=%0d", t, xa_b, fa_b, e_x, e_f);
                else pass_cnt++;
            end
            tick();
        end
        cs_b = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_no_pipe();
        logic [4:0] e_ctl;
        int e_x, e_f, e_o;
        cs_c = 1'b1;
        tick();
        for (int t = 0; t <= 31; t++) begin
            exp_at(t, 4, 1, 0, 5, e_ctl, e_x, e_f, e_o);
            total_cnt++;
            if ({rd_c, ra_c, ea_c, mv_c, dn_c} !== e_ctl)
                $display("FAIL nopipe_ctl t=%0d: got %b want %b (rd,ra,ea,mv,dn)", t, {rd_c, ra_c, ea_c, mv_c, dn_c}, e_ctl);
            else pass_cnt++;
            total_cnt++;
            if (oi_c !== 3'(e_o))
                $display("FAIL nopipe_idx t=%0d: got %0d want %0d", t, oi_c, e_o);
            else pass_cnt++;
            if (e_ctl[4]) begin
                total_cnt++;
                if ({xa_c, fa_c} !== {3'(e_x), 2'(e_f)})
                    $display("FAIL nopipe_addr t=%0d: got x=%0d f=%0d want x=%0d f=%0d", t, xa_c, fa_c, e_x, e_f);
                else pass_cnt++;
            end
            tick();
        end
        cs_c = 1'b0;
        repeat (2) tick();
    endtask

    // Consumer stalls for 5 cycles on output 2 (whose OUTPUT starts at t=20):
    // the whole schedule after that slides by 5 cycles.
    task automatic test_backpressure();
        logic [4:0] e_ctl;
        int e_x, e_f, e_o, tt, mv_cycles;
        mv_cycles = 0;
        cs_a = 1'b1;
        tick();
        for (int t = 0; t <= 41; t++) begin
            tt = (t < 20) ? t : ((t <= 25) ? 20 : t - 5);
            exp_at(tt, 4, 1, 1, 5, e_ctl, e_x, e_f, e_o);
            total_cnt++;
            if ({rd_a, ra_a, ea_a, mv_a, dn_a} !== e_ctl)
                $display("FAIL bp_ctl t=%0d: got %b want %b (rd,ra,ea,mv,dn)", t, {rd_a, ra_a, ea_a, mv_a, dn_a}, e_ctl);
            else pass_cnt++;
            total_cnt++;
            if (oi_a !== 3'(e_o))
                $display("FAIL bp_idx t=%0d: got %0d want %0d", t, oi_a, e_o);
            else pass_cnt++;
            if (t >= 20 && t <= 25 && mv_a === 1'b1) mv_cycles++;
            rdy_a = (t >= 20 && t <= 24) ? 1'b0 : 1'b1;
            tick();
        end
        total_cnt++;
        if (mv_cycles !== 6)
            $display("FAIL bp_valid_len: got %0d cycles want 6", mv_cycles);
        else pass_cnt++;
        rdy_a = 1'b1;
        cs_a = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_abort_accum();
        int bad;
        cs_a = 1'b1;
        tick();
        repeat (3) tick();
        total_cnt++;
        if ({rd_a, ea_a, xa_a, fa_a} !== {1'b1, 1'b1, 3'd2, 2'd2})
            $display("FAIL abort_pre: got rd=%b ea=%b x=%0d f=%0d want 1 1 2 2", rd_a, ea_a, xa_a, fa_a);
        else pass_cnt++;
        cs_a = 1'b0;
        tick();
        total_cnt++;
        if ({rd_a, ra_a, ea_a, mv_a, dn_a} !== 5'b0)
            $display("FAIL abort_idle: got %b want 00000", {rd_a, ra_a, ea_a, mv_a, dn_a});
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (dn_a !== 1'b0 || rd_a !== 1'b0 || ra_a !== 1'b0) bad++;
            tick();
        end
        total_cnt++;
        if (bad !== 0)
            $display("FAIL abort_quiet: got %0d active cycles want 0", bad);
        else pass_cnt++;
        cs_a = 1'b1;
        tick();
        total_cnt++;
        if ({ra_a, rd_a} !== 2'b10)
            $display("FAIL abort_restart_clr: got ra=%b rd=%b want 1 0", ra_a, rd_a);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({rd_a, xa_a, fa_a} !== {1'b1, 3'd0, 2'd0})
            $display("FAIL abort_restart_rd: got rd=%b x=%0d f=%0d want 1 0 0", rd_a, xa_a, fa_a);
        else pass_cnt++;
        cs_a = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_abort_output();
        int bad;
        cs_a = 1'b1;
        tick();
        repeat (6) tick();
        total_cnt++;
        if (mv_a !== 1'b1)
            $display("FAIL abo_valid_t6: got %b want 1", mv_a);
        else pass_cnt++;
        rdy_a = 1'b0;
        cs_a = 1'b0;
        tick();
        total_cnt++;
        if ({mv_a, rd_a} !== 2'b10)
            $display("FAIL abo_hold_t7: got mv=%b rd=%b want 1 0", mv_a, rd_a);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (mv_a !== 1'b1)
            $display("FAIL abo_hold_t8: got %b want 1", mv_a);
        else pass_cnt++;
        rdy_a = 1'b1;
        tick();
        total_cnt++;
        if ({mv_a, ra_a, rd_a, dn_a} !== 4'b0)
            $display("FAIL abo_idle: got mv=%b ra=%b rd=%b dn=%b want 0000", mv_a, ra_a, rd_a, dn_a);
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (dn_a !== 1'b0 || ra_a !== 1'b0 || rd_a !== 1'b0) bad++;
            tick();
        end
        total_cnt++;
        if (bad !== 0)
            $display("FAIL abo_quiet: got %0d active cycles want 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int bad;
        cs_a = 1'b1;
        tick();
        repeat (2) tick();
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({xa_a, fa_a, rd_a, ra_a, ea_a, mv_a, oi_a, dn_a} !== '0)
            $display("FAIL rst_accum: got %b want all zero", {xa_a, fa_a, rd_a, ra_a, ea_a, mv_a, oi_a, dn_a});
        else pass_cnt++;
        repeat (2) tick();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rd_a !== 1'b0 || ra_a !== 1'b0 || mv_a !== 1'b0 || dn_a !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad !== 0)
            $display("FAIL rst_held_start: got %0d active cycles want 0", bad);
        else pass_cnt++;
        cs_a = 1'b0;
        tick();
        cs_a = 1'b1;
        tick();
        total_cnt++;
        if (ra_a !== 1'b1)
            $display("FAIL rst_fresh_edge: got ra=%b want 1", ra_a);
        else pass_cnt++;
        repeat (6) tick();
        total_cnt++;
        if (mv_a !== 1'b1)
            $display("FAIL rst_pre_output: got mv=%b want 1", mv_a);
        else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({xa_a, fa_a, rd_a, ra_a, ea_a, mv_a, oi_a, dn_a} !== '0)
            $display("FAIL rst_output: got %b want all zero", {xa_a, fa_a, rd_a, ra_a, ea_a, mv_a, oi_a, dn_a});
        else pass_cnt++;
        tick();
        reset = 1'b0;
        cs_a = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_stride_pipe();
        test_no_pipe();
        test_backpressure();
        test_abort_accum();
        test_abort_output();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
